// File: rtl/lsu_pkg.sv
// Shared types for the load/store unit.
// Access size encodings, FSM states and the captured control bundle.
package lsu_pkg;

    localparam logic [1:0] SIZE_B = 2'd0;
    localparam logic [1:0] SIZE_H = 2'd1;
    localparam logic [1:0] SIZE_W = 2'd2;
    localparam logic [1:0] SIZE_D = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_REQ,
        ST_WAIT,
        ST_RESP
    } lsu_state_e;

    typedef struct packed {
        logic       we;
        logic [1:0] size;
        logic       uns;
        logic       mis;
    } lsu_ctl_t;

endpackage

// File: rtl/lsu_align.sv
// Byte-lane steering for the load/store unit.
// Builds byte enables, replicates store data, extracts and extends loads.
module lsu_align
    import lsu_pkg::*;
#(
    parameter int XLEN = 32,
    localparam int NB = XLEN / 8,
    localparam int LW = $clog2(NB)
) (
    input  logic [1:0]      size,
    input  logic [LW-1:0]   lane,
    input  logic            uns,
    input  logic [XLEN-1:0] wdata,
    input  logic [XLEN-1:0] rdata,
    output logic [NB-1:0]   be,
    output logic [XLEN-1:0] wdata_rep,
    output logic [XLEN-1:0] rdata_ext
);

    // Store side: lane mask shifted to the byte offset, data tiled across lanes
    always_comb begin
        int bytes;
        bytes = 1 << size;
        be = NB'((1 << bytes) - 1) << lane;
        for (int i = 0; i < NB; i++) begin
            wdata_rep[8*i +: 8] = wdata[8*(i % bytes) +: 8];
        end
    end

    // Load side: shift lane down, keep the access width, extend the rest
    always_comb begin
        logic [XLEN-1:0] sh;
        logic [XLEN-1:0] mask;
        logic            sign;
        int              nbits;
        sh = rdata >> {lane, 3'b000};
        unique case (size)
            SIZE_B:  nbits = 8;
            SIZE_H:  nbits = 16;
            SIZE_W:  nbits = 32;
            SIZE_D:  nbits = 64;
            default: nbits = 8;
        endcase
        if (nbits > XLEN) nbits = XLEN;
        sign = 1'b0;
        for (int i = 0; i < XLEN; i++) begin
            mask[i] = (i < nbits);
            if (i == nbits - 1) sign = sh[i];
        end
        rdata_ext = (sh & mask) | ((sign && !uns) ? ~mask : '0);
    end

endmodule

// File: rtl/lsu.sv
// Load/store unit for the MEMORY stage.
// One access at a time over a req/gnt/rvalid bus, with timeout abort.
module lsu
    import lsu_pkg::*;
#(
    parameter int XLEN    = 32,
    parameter int TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid_i,
    output logic              req_ready_o,
    input  logic              req_we_i,
    input  logic [1:0]        req_size_i,
    input  logic              req_unsigned_i,
    input  logic [XLEN-1:0]   req_addr_i,
    input  logic [XLEN-1:0]   req_wdata_i,
    output logic              rsp_valid_o,
    output logic [XLEN-1:0]   rsp_rdata_o,
    output logic              rsp_misalign_o,
    output logic              rsp_bus_err_o,
    output logic [XLEN-1:0]   rsp_addr_o,
    output logic              busy_o,
    output logic              mem_req_o,
    output logic              mem_we_o,
    output logic [XLEN/8-1:0] mem_be_o,
    output logic [XLEN-1:0]   mem_addr_o,
    output logic [XLEN-1:0]   mem_wdata_o,
    input  logic              mem_gnt_i,
    input  logic              mem_rvalid_i,
    input  logic [XLEN-1:0]   mem_rdata_i,
    input  logic              mem_err_i
);

    localparam int NB = XLEN / 8;
    localparam int LW = $clog2(NB);
    localparam int CW = $clog2(TIMEOUT);
    localparam logic [1:0] MAX_SIZE = 2'(LW);

    lsu_state_e      state_q, state_d;
    lsu_ctl_t        ctl_q;
    logic [XLEN-1:0] addr_q;
    logic [XLEN-1:0] wdata_q;
    logic [XLEN-1:0] rdata_q;
    logic            err_q;
    logic [CW-1:0]   cnt_q;

    logic            capture;
    logic            mis_in;
    logic            in_bus;
    logic            done;
    logic            tmo;
    logic [NB-1:0]   be;
    logic [XLEN-1:0] wdata_rep;
    logic [XLEN-1:0] rdata_ext;

    assign capture = req_valid_i && (state_q == ST_IDLE);
    assign mis_in  = (req_size_i > MAX_SIZE) ||
                     (|(req_addr_i & ((XLEN'(1) << req_size_i) - 1'b1)));
    assign in_bus  = (state_q == ST_REQ) || (state_q == ST_WAIT);
    assign done    = ((state_q == ST_REQ) && mem_gnt_i && mem_rvalid_i) ||
                     ((state_q == ST_WAIT) && mem_rvalid_i);
    assign tmo     = in_bus && (cnt_q == CW'(TIMEOUT - 1));

    lsu_align #(.XLEN(XLEN)) u_align (
        .size      (ctl_q.size),
        .lane      (addr_q[LW-1:0]),
        .uns       (ctl_q.uns),
        .wdata     (wdata_q),
        .rdata     (mem_rdata_i),
        .be        (be),
        .wdata_rep (wdata_rep),
        .rdata_ext (rdata_ext)
    );

    // FSM next state
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: if (capture) state_d = mis_in ? ST_RESP : ST_REQ;
            ST_REQ: begin
                if (done || tmo)    state_d = ST_RESP;
                else if (mem_gnt_i) state_d = ST_WAIT;
            end
            ST_WAIT: if (done || tmo) state_d = ST_RESP;
            ST_RESP: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // State, captured request, response data and timeout counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            ctl_q   <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= in_bus ? cnt_q + 1'b1 : '0;
            if (capture) begin
                ctl_q   <= '{we: req_we_i, size: req_size_i,
                             uns: req_unsigned_i, mis: mis_in};
                addr_q  <= req_addr_i;
                wdata_q <= req_wdata_i;
                rdata_q <= '0;
                err_q   <= 1'b0;
            end else if (done) begin
                err_q   <= mem_err_i;
                rdata_q <= (mem_err_i || ctl_q.we) ? '0 : rdata_ext;
            end else if (tmo) begin
                err_q   <= 1'b1;
                rdata_q <= '0;
            end
        end
    end

    assign req_ready_o    = (state_q == ST_IDLE);
    assign busy_o         = (state_q != ST_IDLE);
    assign rsp_valid_o    = (state_q == ST_RESP);
    assign rsp_rdata_o    = rsp_valid_o ? rdata_q : '0;
    assign rsp_misalign_o = rsp_valid_o && ctl_q.mis;
    assign rsp_bus_err_o  = rsp_valid_o && err_q;
    assign rsp_addr_o     = rsp_valid_o ? addr_q : '0;
    assign mem_req_o      = (state_q == ST_REQ);
    assign mem_we_o       = mem_req_o && ctl_q.we;
    assign mem_be_o       = mem_req_o ? be : '0;
    assign mem_addr_o     = mem_req_o ? {addr_q[XLEN-1:LW], {LW{1'b0}}} : '0;
    assign mem_wdata_o    = mem_req_o ? wdata_rep : '0;

endmodule

// File: tb/tb_lsu.sv
// Directed testbench for the load/store unit.
// Each task drives one scenario and checks hand-computed values.
module tb_lsu;

    logic        clk;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_uns;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_mis;
    logic        rsp_err;
    logic [31:0] rsp_addr;
    logic        busy;
    logic        mem_req;
    logic        mem_we;
    logic [3:0]  mem_be;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_gnt;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;
    logic        mem_err;

    int vectors;
    int miscompares;

    logic        s_req, s_we;
    logic [3:0]  s_be;
    logic [31:0] s_addr, s_wdata;
    int          lat;
    logic        r_valid, r_mis, r_err;
    logic [31:0] r_rdata, r_addr;

    lsu #(.XLEN(32), .TIMEOUT(16)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .req_valid_i    (req_valid),
        .req_ready_o    (req_ready),
        .req_we_i       (req_we),
        .req_size_i     (req_size),
        .req_unsigned_i (req_uns),
        .req_addr_i     (req_addr),
        .req_wdata_i    (req_wdata),
        .rsp_valid_o    (rsp_valid),
        .rsp_rdata_o    (rsp_rdata),
        .rsp_misalign_o (rsp_mis),
        .rsp_bus_err_o  (rsp_err),
        .rsp_addr_o     (rsp_addr),
        .busy_o         (busy),
        .mem_req_o      (mem_req),
        .mem_we_o       (mem_we),
        .mem_be_o       (mem_be),
        .mem_addr_o     (mem_addr),
        .mem_wdata_o    (mem_wdata),
        .mem_gnt_i      (mem_gnt),
        .mem_rvalid_i   (mem_rvalid),
        .mem_rdata_i    (mem_rdata),
        .mem_err_i      (mem_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present a request for one cycle, then scramble the inputs
    task automatic issue(input logic we, input logic [1:0] size,
                         input logic uns, input logic [31:0] addr,
                         input logic [31:0] wdata);
        req_we    = we;
        req_size  = size;
        req_uns   = uns;
        req_addr  = addr;
        req_wdata = wdata;
        req_valid = 1'b1;
        step();
        req_valid = 1'b0;
        req_we    = ~we;
        req_size  = 2'd0;
        req_addr  = 32'hFFFF_FFF0;
        req_wdata = 32'h0;
    endtask

    // One bus access: gnt in the first REQ cycle, rvalid then or one later
    task automatic run_access(input logic we, input logic [1:0] size,
                              input logic uns, input logic [31:0] addr,
                              input logic [31:0] wdata,
                              input logic [31:0] rdata,
                              input logic err, input logic same);
        issue(we, size, uns, addr, wdata);
        lat     = 1;
        s_req   = mem_req;
        s_we    = mem_we;
        s_be    = mem_be;
        s_addr  = mem_addr;
        s_wdata = mem_wdata;
        mem_gnt = 1'b1;
        if (same) begin
            mem_rvalid = 1'b1;
            mem_rdata  = rdata;
            mem_err    = err;
        end
        step();
        lat        = 2;
        mem_gnt    = 1'b0;
        mem_rvalid = 1'b0;
        mem_err    = 1'b0;
        if (!same) begin
            mem_rvalid = 1'b1;
            mem_rdata  = rdata;
            mem_err    = err;
            step();
            lat        = 3;
            mem_rvalid = 1'b0;
            mem_err    = 1'b0;
        end
        for (int i = 0; i < 8 && rsp_valid !== 1'b1; i++) begin
            step();
            lat++;
        end
        r_valid = rsp_valid;
        r_rdata = rsp_rdata;
        r_mis   = rsp_mis;
        r_err   = rsp_err;
        r_addr  = rsp_addr;
        mem_rdata = 32'h0;
        step();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #2;
        vectors++;
        if (req_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_ready got %b want 1", req_ready);
        end
        vectors++;
        if ({rsp_valid, rsp_mis, rsp_err, busy, mem_req, mem_we} !== 6'b0) begin
            miscompares++;
            $display("FAIL reset_flags got %b want 000000",
                     {rsp_valid, rsp_mis, rsp_err, busy, mem_req, mem_we});
        end
        vectors++;
        if ({rsp_rdata, rsp_addr, mem_addr, mem_wdata, mem_be} !== 132'b0) begin
            miscompares++;
            $display("FAIL reset_data got %h want 0",
                     {rsp_rdata, rsp_addr, mem_addr, mem_wdata, mem_be});
        end
        step();
        step();
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_lw();
        run_access(1'b0, 2'd2, 1'b0, 32'h100, 32'h0, 32'hDEADBEEF, 1'b0, 1'b0);
        vectors++;
        if (s_req !== 1'b1 || s_we !== 1'b0) begin
            miscompares++;
            $display("FAIL lw_req got req=%b we=%b want 1 0", s_req, s_we);
        end
        vectors++;
        if (s_addr !== 32'h100 || s_be !== 4'b1111) begin
            miscompares++;
            $display("FAIL lw_bus got %h/%b want 00000100/1111", s_addr, s_be);
        end
        vectors++;
        if (r_valid !== 1'b1 || lat != 3) begin
            miscompares++;
            $display("FAIL lw_latency got v=%b lat=%0d want 1 3", r_valid, lat);
        end
        vectors++;
        if (r_rdata !== 32'hDEADBEEF || r_mis !== 1'b0 || r_err !== 1'b0) begin
            miscompares++;
            $display("FAIL lw_rsp got %h m=%b e=%b want deadbeef 0 0",
                     r_rdata, r_mis, r_err);
        end
        vectors++;
        if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL lw_pulse got v=%b rdy=%b want 0 1", rsp_valid, req_ready);
        end
    endtask

    task automatic test_load_extend();
        run_access(1'b0, 2'd0, 1'b0, 32'h103, 32'h0, 32'h80000000, 1'b0, 1'b0);
        vectors++;
        if (r_rdata !== 32'hFFFFFF80 || s_be !== 4'b1000 || s_addr !== 32'h100) begin
            miscompares++;
            $display("FAIL lb got %h be=%b a=%h want ffffff80 1000 00000100",
                     r_rdata, s_be, s_addr);
        end
        run_access(1'b0, 2'd0, 1'b1, 32'h103, 32'h0, 32'h80000000, 1'b0, 1'b0);
        vectors++;
        if (r_rdata !== 32'h00000080 || s_be !== 4'b1000) begin
            miscompares++;
            $display("FAIL lbu got %h be=%b want 00000080 1000", r_rdata, s_be);
        end
        run_access(1'b0, 2'd1, 1'b0, 32'h102, 32'h0, 32'h80010000, 1'b0, 1'b0);
        vectors++;
        if (r_rdata !== 32'hFFFF8001 || s_be !== 4'b1100) begin
            miscompares++;
            $display("FAIL lh got %h be=%b want ffff8001 1100", r_rdata, s_be);
        end
        run_access(1'b0, 2'd1, 1'b1, 32'h102, 32'h0, 32'h80010000, 1'b0, 1'b0);
        vectors++;
        if (r_rdata !== 32'h00008001) begin
            miscompares++;
            $display("FAIL lhu got %h want 00008001", r_rdata);
        end
    endtask

    task automatic test_store();
        run_access(1'b1, 2'd1, 1'b0, 32'h102, 32'h00001234, 32'hFFFFFFFF, 1'b0, 1'b0);
        vectors++;
        if (s_addr !== 32'h100 || s_be !== 4'b1100 || s_we !== 1'b1) begin
            miscompares++;
            $display("FAIL sh_bus got %h be=%b we=%b want 00000100 1100 1",
                     s_addr, s_be, s_we);
        end
        vectors++;
        if (s_wdata !== 32'h12341234) begin
            miscompares++;
            $display("FAIL sh_wdata got %h want 12341234", s_wdata);
        end
        vectors++;
        if (r_valid !== 1'b1 || r_rdata !== 32'h0) begin
            miscompares++;
            $display("FAIL sh_rsp got v=%b %h want 1 00000000", r_valid, r_rdata);
        end
        run_access(1'b1, 2'd0, 1'b0, 32'h101, 32'h000000AB, 32'h0, 1'b0, 1'b0);
        vectors++;
        if (s_wdata !== 32'hABABABAB || s_be !== 4'b0010) begin
            miscompares++;
            $display("FAIL sb got %h be=%b want abababab 0010", s_wdata, s_be);
        end
    endtask

    task automatic test_misalign();
        issue(1'b0, 2'd2, 1'b0, 32'h102, 32'h0);
        vectors++;
        if (mem_req !== 1'b0 || rsp_valid !== 1'b1 || rsp_mis !== 1'b1) begin
            miscompares++;
            $display("FAIL mis_lw got req=%b v=%b m=%b want 0 1 1",
                     mem_req, rsp_valid, rsp_mis);
        end
        vectors++;
        if (rsp_addr !== 32'h102 || rsp_rdata !== 32'h0 || rsp_err !== 1'b0) begin
            miscompares++;
            $display("FAIL mis_lw_addr got %h %h e=%b want 00000102 0 0",
                     rsp_addr, rsp_rdata, rsp_err);
        end
        step();
        issue(1'b0, 2'd3, 1'b0, 32'h100, 32'h0);
        vectors++;
        if (mem_req !== 1'b0 || rsp_valid !== 1'b1 || rsp_mis !== 1'b1) begin
            miscompares++;
            $display("FAIL mis_size got req=%b v=%b m=%b want 0 1 1",
                     mem_req, rsp_valid, rsp_mis);
        end
        step();
    endtask

    task automatic test_error();
        run_access(1'b0, 2'd2, 1'b0, 32'h104, 32'h0, 32'h12345678, 1'b1, 1'b0);
        vectors++;
        if (r_valid !== 1'b1 || r_err !== 1'b1 || r_rdata !== 32'h0) begin
            miscompares++;
            $display("FAIL bus_err got v=%b e=%b %h want 1 1 00000000",
                     r_valid, r_err, r_rdata);
        end
    endtask

    task automatic test_timeout();
        int n;
        n = 0;
        issue(1'b0, 2'd2, 1'b0, 32'h300, 32'h0);
        for (int i = 0; i < 40 && rsp_valid !== 1'b1; i++) begin
            if (mem_req === 1'b1) n++;
            step();
        end
        vectors++;
        if (n != 16 || rsp_valid !== 1'b1) begin
            miscompares++;
            $display("FAIL tmo_len got req_cycles=%0d v=%b want 16 1", n, rsp_valid);
        end
        vectors++;
        if (rsp_err !== 1'b1 || rsp_rdata !== 32'h0 || mem_req !== 1'b0) begin
            miscompares++;
            $display("FAIL tmo_rsp got e=%b %h req=%b want 1 00000000 0",
                     rsp_err, rsp_rdata, mem_req);
        end
        step();
        mem_rvalid = 1'b1;
        mem_rdata  = 32'h11111111;
        step();
        mem_rvalid = 1'b0;
        vectors++;
        if (rsp_valid !== 1'b0 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL tmo_late got v=%b busy=%b want 0 0", rsp_valid, busy);
        end
        run_access(1'b0, 2'd2, 1'b0, 32'h104, 32'h0, 32'h0BADF00D, 1'b0, 1'b0);
        vectors++;
        if (r_valid !== 1'b1 || r_rdata !== 32'h0BADF00D || r_err !== 1'b0) begin
            miscompares++;
            $display("FAIL tmo_next got v=%b %h e=%b want 1 0badf00d 0",
                     r_valid, r_rdata, r_err);
        end
    endtask

    task automatic test_reset_mid();
        issue(1'b0, 2'd2, 1'b0, 32'h400, 32'h0);
        mem_gnt = 1'b1;
        step();
        mem_gnt = 1'b0;
        rst_n = 1'b0;
        #1;
        vectors++;
        if ({rsp_valid, busy, mem_req} !== 3'b0 || req_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL rst_mid got v=%b busy=%b req=%b rdy=%b want 0 0 0 1",
                     rsp_valid, busy, mem_req, req_ready);
        end
        step();
        rst_n = 1'b1;
        mem_rvalid = 1'b1;
        mem_rdata  = 32'h55555555;
        step();
        mem_rvalid = 1'b0;
        vectors++;
        if (rsp_valid !== 1'b0 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL rst_stray got v=%b busy=%b want 0 0", rsp_valid, busy);
        end
        run_access(1'b1, 2'd2, 1'b0, 32'h200, 32'hCAFEF00D, 32'h0, 1'b0, 1'b1);
        vectors++;
        if (r_valid !== 1'b1 || lat != 2 || r_rdata !== 32'h0) begin
            miscompares++;
            $display("FAIL sw_same got v=%b lat=%0d %h want 1 2 00000000",
                     r_valid, lat, r_rdata);
        end
        vectors++;
        if (s_wdata !== 32'hCAFEF00D || s_be !== 4'b1111 || s_addr !== 32'h200) begin
            miscompares++;
            $display("FAIL sw_bus got %h be=%b a=%h want cafef00d 1111 00000200",
                     s_wdata, s_be, s_addr);
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        req_valid   = 1'b0;
        req_we      = 1'b0;
        req_size    = 2'd0;
        req_uns     = 1'b0;
        req_addr    = 32'h0;
        req_wdata   = 32'h0;
        mem_gnt     = 1'b0;
        mem_rvalid  = 1'b0;
        mem_rdata   = 32'h0;
        mem_err     = 1'b0;
        test_reset();
        test_lw();
        test_load_extend();
        test_store();
        test_misalign();
        test_error();
        test_timeout();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
